// File: rtl/svn_seg_mux_cntr_if.sv
// svn_seg_mux_cntr_if: control inputs and display/count outputs of the 7-segment counter.
// Latency: none, wiring only.
// Backpressure: none; the control side drives the inputs and the display side drives the outputs.
interface svn_seg_mux_cntr_if #(
    parameter int NUM_DIGITS = 3
);
    logic                      en_i;
    logic                      clr_i;
    logic                      up_dn_i;
    logic [NUM_DIGITS-1:0]     dp_i;
    logic [4*NUM_DIGITS-1:0]   count_o;
    logic                      wrap_o;
    logic [7:0]                seg_display_o;
    logic [NUM_DIGITS-1:0]     seg_sel_o;

    // Control source: drives enable/clear/direction/decimal points, observes the display.
    modport master (
        output en_i, clr_i, up_dn_i, dp_i,
        input  count_o, wrap_o, seg_display_o, seg_sel_o
    );

    // Display driver: consumes the controls, produces count and pin-level outputs.
    modport slave (
        input  en_i, clr_i, up_dn_i, dp_i,
        output count_o, wrap_o, seg_display_o, seg_sel_o
    );
endinterface

// File: rtl/svn_seg_mux_cntr.sv
// svn_seg_mux_cntr: N-digit hex/BCD up/down counter with time-multiplexed 7-segment drive (SVN_SEG_LZB_EN adds leading-zero blanking).
// Latency: count/wrap update on the tick edge; segment/select outputs are registered and change only at slot boundaries.
// Backpressure: none; the scan free-runs, en_i freezes only the count prescaler and count, clr_i clears them.
module svn_seg_mux_cntr #(
    parameter int NUM_DIGITS   = 3,
    parameter int COUNT_DIV    = 125000000,
    parameter int SCAN_DIV     = 125000,
    parameter int BLANK_CYC    = 64,
    parameter bit BCD_MODE     = 1'b0,
    parameter bit LED_POLARITY = 1'b0,
    parameter bit SEL_POLARITY = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    svn_seg_mux_cntr_if.slave io_bus
);

    // Counter widths sized so a 1-valued divider still has a legal 1-bit register.
    localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] C_TERM = CW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] B_TERM = SW'(BLANK_CYC - 1);
    localparam logic [SW-1:0] D_TERM = SW'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]    DMAX   = BCD_MODE ? 4'd9 : 4'd15;

    localparam logic [7:0]            SEG_OFF = LED_POLARITY ? 8'h00 : 8'hFF;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{~SEL_POLARITY}};

    // Scan FSM encoding.
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // Count path state.
    logic [CW-1:0]           r_cpre;
    logic [4*NUM_DIGITS-1:0] r_count;
    logic                    r_wrap;

    // Scan path state.
    logic [0:0]              r_state;
    logic [SW-1:0]           r_scnt;
    logic [IW-1:0]           r_idx;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_sel;

    // Combinational helpers.
    logic                    w_tick;
    logic [4*NUM_DIGITS-1:0] w_count_nxt;
    logic                    w_carry;
    logic [3:0]              w_dig;
    logic [3:0]              w_cur_dig;
    logic                    w_cur_dp;
    logic                    w_blank_dig;
    logic [7:0]              w_pat;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_sel_drive;
`ifdef SVN_SEG_LZB_EN
    logic                    w_hi_zero;
`endif

    // Active-high 7-segment pattern, bit0=a .. bit6=g.
    function automatic logic [6:0] f_hex7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // A tick is the enabled cycle on which the prescaler sits at its terminal value.
    assign w_tick = io_bus.en_i && (r_cpre == C_TERM);

    // Ripple increment/decrement across digits; carry out of the top digit marks a full wrap.
    always_comb begin
        w_count_nxt = r_count;
        w_carry     = 1'b1;
        w_dig       = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_dig = r_count[4*k +: 4];
            if (w_carry) begin
                if (io_bus.up_dn_i) begin
                    if (w_dig == DMAX) begin
                        w_count_nxt[4*k +: 4] = 4'd0;
                    end else begin
                        w_count_nxt[4*k +: 4] = w_dig + 4'd1;
                        w_carry               = 1'b0;
                    end
                end else begin
                    if (w_dig == 4'd0) begin
                        w_count_nxt[4*k +: 4] = DMAX;
                    end else begin
                        w_count_nxt[4*k +: 4] = w_dig - 4'd1;
                        w_carry               = 1'b0;
                    end
                end
            end
        end
    end

    // Prescaler and count; clear outranks a tick and suppresses the wrap pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i || io_bus.clr_i) begin
            r_cpre  <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_tick) begin
            r_cpre  <= '0;
            r_count <= w_count_nxt;
            r_wrap  <= w_carry;
        end else begin
            if (io_bus.en_i) begin
                r_cpre <= r_cpre + CW'(1);
            end
            r_wrap <= 1'b0;
        end
    end

    // Pick the digit and decimal point for the slot about to be driven, scanning from the top
    // digit down so leading-zero status is known when the selected digit is reached.
    always_comb begin
        w_cur_dig   = 4'd0;
        w_cur_dp    = 1'b0;
        w_blank_dig = 1'b0;
`ifdef SVN_SEG_LZB_EN
        w_hi_zero   = 1'b1;
`endif
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef SVN_SEG_LZB_EN
            w_hi_zero = w_hi_zero && (r_count[4*k +: 4] == 4'd0);
`endif
            if (IW'(k) == r_idx) begin
                w_cur_dig = r_count[4*k +: 4];
                w_cur_dp  = io_bus.dp_i[k];
`ifdef SVN_SEG_LZB_EN
                // Digit 0 always shows, so a zero count still reads "0".
                w_blank_dig = w_hi_zero && (k != 0);
`endif
            end
        end
    end

    // Decimal point survives blanking; polarity applied last.
    assign w_pat     = {w_cur_dp, (w_blank_dig ? 7'h00 : f_hex7(w_cur_dig))};
    assign w_seg_nxt = LED_POLARITY ? w_pat : ~w_pat;

    // One-hot select for the current scan index, in board polarity.
    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_onehot[k] = (IW'(k) == r_idx);
        end
    end

    assign w_sel_drive = SEL_POLARITY ? w_onehot : ~w_onehot;

    // Scan FSM: blank interval then drive interval per digit; segments latched on entry to DRIVE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_BLANK;
            r_scnt  <= '0;
            r_idx   <= '0;
            r_seg   <= SEG_OFF;
            r_sel   <= SEL_OFF;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_scnt == B_TERM) begin
                        r_state <= ST_DRIVE;
                        r_scnt  <= '0;
                        r_seg   <= w_seg_nxt;
                        r_sel   <= w_sel_drive;
                    end else begin
                        r_scnt  <= r_scnt + SW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (r_scnt == D_TERM) begin
                        r_state <= ST_BLANK;
                        r_scnt  <= '0;
                        r_seg   <= SEG_OFF;
                        r_sel   <= SEL_OFF;
                        r_idx   <= (r_idx == I_LAST) ? '0 : r_idx + IW'(1);
                    end else begin
                        r_scnt  <= r_scnt + SW'(1);
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_scnt  <= '0;
                    r_seg   <= SEG_OFF;
                    r_sel   <= SEL_OFF;
                end
            endcase
        end
    end

    assign io_bus.count_o       = r_count;
    assign io_bus.wrap_o        = r_wrap;
    assign io_bus.seg_display_o = r_seg;
    assign io_bus.seg_sel_o     = r_sel;

endmodule

// File: tb/tb_svn_seg_mux_cntr.sv
// tb_svn_seg_mux_cntr: two display drivers (hex/active-low segments, BCD/active-high segments/active-low selects).
// Latency: reference model tracks each clock edge; outputs sampled on the falling edge.
// Backpressure: none; stimulus driven on the falling edge.
module tb_svn_seg_mux_cntr;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    svn_seg_mux_cntr_if #(.NUM_DIGITS(3)) ha ();
    svn_seg_mux_cntr_if #(.NUM_DIGITS(3)) hb ();

    svn_seg_mux_cntr #(
        .NUM_DIGITS(3), .COUNT_DIV(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .BCD_MODE(1'b0), .LED_POLARITY(1'b0), .SEL_POLARITY(1'b1)
    ) u_hex (
        .clk_i (clk),
        .rst_i (rst_a),
        .io_bus(ha)
    );

    svn_seg_mux_cntr #(
        .NUM_DIGITS(3), .COUNT_DIV(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .BCD_MODE(1'b1), .LED_POLARITY(1'b1), .SEL_POLARITY(1'b0)
    ) u_bcd (
        .clk_i (clk),
        .rst_i (rst_b),
        .io_bus(hb)
    );

    // Reference model: count held as an integer in [0, range), display position from cycles since reset.
    int         m_cnt [2];
    int         m_pre [2];
    int         m_t   [2];
    int         m_lat [2];
    bit         m_wrap[2];
    logic [2:0] m_latdp[2];

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[d];
    endfunction

    function automatic logic [11:0] exp_count(input int i);
        int c;
        c = m_cnt[i];
        if (i == 0) return 12'(c);
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [2:0] exp_sel(input int i);
        logic [2:0] oh;
        if ((m_t[i] % 8) < 2) oh = 3'b000;
        else oh = 3'b001 << ((m_t[i] / 8) % 3);
        return (i == 0) ? oh : ~oh;
    endfunction

    function automatic logic [7:0] exp_seg(input int i);
        logic [7:0] p;
        int idx, base, pw, d;
        p = 8'h00;
        if ((m_t[i] % 8) >= 2) begin
            idx  = (m_t[i] / 8) % 3;
            base = (i == 0) ? 16 : 10;
            pw   = (idx == 0) ? 1 : ((idx == 1) ? base : base * base);
            d    = (m_lat[i] / pw) % base;
            p    = {m_latdp[i][idx], hex7(d[3:0])};
`ifdef SVN_SEG_LZB_EN
            if (idx != 0 && m_lat[i] < pw) p[6:0] = 7'h00;
`endif
        end
        return (i == 1) ? p : ~p;
    endfunction

    function automatic logic [23:0] exp_vec(input int i);
        return {exp_count(i), m_wrap[i], exp_sel(i), exp_seg(i)};
    endfunction

    // Advance one clock: capture inputs, let the edge happen, update the model, move to the sampling point.
    task automatic step();
        logic       rs [2];
        logic       en [2];
        logic       cl [2];
        logic       up [2];
        logic [2:0] dp [2];
        int         rng;
        rs[0] = rst_a;   rs[1] = rst_b;
        en[0] = ha.en_i; en[1] = hb.en_i;
        cl[0] = ha.clr_i; cl[1] = hb.clr_i;
        up[0] = ha.up_dn_i; up[1] = hb.up_dn_i;
        dp[0] = ha.dp_i; dp[1] = hb.dp_i;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            rng = (i == 0) ? 4096 : 1000;
            if (rs[i]) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 1'b0; m_t[i] = 0;
            end else begin
                m_t[i]++;
                if ((m_t[i] % 8) == 2) begin
                    m_lat[i]   = m_cnt[i];
                    m_latdp[i] = dp[i];
                end
                if (cl[i]) begin
                    m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 1'b0;
                end else if (en[i] && m_pre[i] == 3) begin
                    m_pre[i] = 0;
                    if (up[i]) begin
                        m_wrap[i] = (m_cnt[i] == rng - 1);
                        m_cnt[i]  = (m_cnt[i] + 1) % rng;
                    end else begin
                        m_wrap[i] = (m_cnt[i] == 0);
                        m_cnt[i]  = (m_cnt[i] + rng - 1) % rng;
                    end
                end else begin
                    if (en[i]) m_pre[i]++;
                    m_wrap[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) step();
        checks++;
        if ({ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o} !== {12'h000, 1'b0, 3'b000, 8'hFF}) begin
            errors++;
            $display("FAIL reset_hex: got %h want %h", {ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o}, {12'h000, 1'b0, 3'b000, 8'hFF});
        end
        checks++;
        if ({hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o} !== {12'h000, 1'b0, 3'b111, 8'h00}) begin
            errors++;
            $display("FAIL reset_bcd: got %h want %h", {hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o}, {12'h000, 1'b0, 3'b111, 8'h00});
        end
        rst_b = 1'b0;
    endtask

    task automatic test_idle_scan();
        logic [2:0]  es;
        logic [7:0]  eg;
        ha.en_i = 1'b0;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        for (int c = 0; c < 24; c++) begin
            es = ((c % 8) < 2) ? 3'b000 : (3'b001 << ((c / 8) % 3));
            eg = ((c % 8) < 2) ? 8'hFF : 8'hC0;
            checks++;
            if ({ha.count_o, ha.seg_sel_o, ha.seg_display_o} !== {12'h000, es, eg}) begin
                errors++;
                $display("FAIL idle_scan c=%0d: got %h want %h", c, {ha.count_o, ha.seg_sel_o, ha.seg_display_o}, {12'h000, es, eg});
            end
            step();
        end
    endtask

    task automatic test_count_up_wrap();
        int          wraps;
        logic [11:0] prev;
        wraps = 0;
        ha.en_i = 1'b1; ha.up_dn_i = 1'b1;
        prev = ha.count_o;
        for (int c = 0; c < 4096 * 4 + 4; c++) begin
            if ((c % 8) == 0) ha.dp_i = 3'($urandom_range(0, 7));
            step();
            checks++;
            if ({ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o} !== exp_vec(0)) begin
                errors++;
                $display("FAIL up_count c=%0d: got %h want %h", c, {ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o}, exp_vec(0));
            end
            if (ha.wrap_o === 1'b1) begin
                wraps++;
                checks++;
                if ({prev, ha.count_o} !== {12'hFFF, 12'h000}) begin
                    errors++;
                    $display("FAIL up_wrap_edge: got %h->%h want FFF->000", prev, ha.count_o);
                end
            end
            prev = ha.count_o;
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL up_wrap_pulses: got %0d want 1", wraps);
        end
    endtask

    task automatic test_count_down();
        ha.clr_i = 1'b1;
        step();
        ha.clr_i = 1'b0; ha.up_dn_i = 1'b0; ha.en_i = 1'b1;
        repeat (4) step();
        checks++;
        if ({ha.count_o, ha.wrap_o} !== {12'hFFF, 1'b1}) begin
            errors++;
            $display("FAIL down_wrap: got %h/%b want FFF/1", ha.count_o, ha.wrap_o);
        end
        step();
        checks++;
        if ({ha.count_o, ha.wrap_o} !== {12'hFFF, 1'b0}) begin
            errors++;
            $display("FAIL down_wrap_once: got %h/%b want FFF/0", ha.count_o, ha.wrap_o);
        end
        repeat (3) step();
        checks++;
        if ({ha.count_o, ha.wrap_o} !== {12'hFFE, 1'b0}) begin
            errors++;
            $display("FAIL down_next: got %h/%b want FFE/0", ha.count_o, ha.wrap_o);
        end
    endtask

    task automatic test_clear();
        int guard;
        ha.clr_i = 1'b1;
        step();
        ha.clr_i = 1'b0; ha.up_dn_i = 1'b1; ha.en_i = 1'b1;
        guard = 0;
        while (!(m_cnt[0] == 255 && m_pre[0] == 3) && guard < 1100) begin
            step();
            guard++;
            checks++;
            if ({ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o} !== exp_vec(0)) begin
                errors++;
                $display("FAIL clr_run: got %h want %h", {ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o}, exp_vec(0));
            end
        end
        checks++;
        if (ha.count_o !== 12'h0FF) begin
            errors++;
            $display("FAIL clr_reach: got %h want 0FF", ha.count_o);
        end
        ha.clr_i = 1'b1;
        step();
        ha.clr_i = 1'b0;
        checks++;
        if ({ha.count_o, ha.wrap_o} !== {12'h000, 1'b0}) begin
            errors++;
            $display("FAIL clr_on_tick: got %h/%b want 000/0", ha.count_o, ha.wrap_o);
        end
        repeat (3) step();
        checks++;
        if (ha.count_o !== 12'h000) begin
            errors++;
            $display("FAIL clr_hold3: got %h want 000", ha.count_o);
        end
        step();
        checks++;
        if (ha.count_o !== 12'h001) begin
            errors++;
            $display("FAIL clr_restart: got %h want 001", ha.count_o);
        end
    endtask

    task automatic test_rst_mid_drive();
        int guard;
        guard = 0;
        while ((m_t[0] % 8) != 4 && guard < 16) begin
            step();
            guard++;
        end
        checks++;
        if ({ha.seg_sel_o, ha.seg_display_o} !== {exp_sel(0), exp_seg(0)} || ha.seg_sel_o === 3'b000) begin
            errors++;
            $display("FAIL mid_drive: got %h want %h", {ha.seg_sel_o, ha.seg_display_o}, {exp_sel(0), exp_seg(0)});
        end
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        checks++;
        if ({ha.count_o, ha.seg_sel_o, ha.seg_display_o} !== {12'h000, 3'b000, 8'hFF}) begin
            errors++;
            $display("FAIL rst_mid_drive: got %h want %h", {ha.count_o, ha.seg_sel_o, ha.seg_display_o}, {12'h000, 3'b000, 8'hFF});
        end
    endtask

    task automatic test_lzb();
        int         guard;
        logic [7:0] eg;
        ha.clr_i = 1'b1; ha.dp_i = 3'b000;
        step();
        ha.clr_i = 1'b0; ha.en_i = 1'b1; ha.up_dn_i = 1'b1;
        guard = 0;
        while (!(m_cnt[0] == 5) && guard < 40) begin
            step();
            guard++;
        end
        ha.en_i = 1'b0;
        repeat (24) step();
        for (int c = 0; c < 24; c++) begin
            if (ha.seg_sel_o !== 3'b000) begin
`ifdef SVN_SEG_LZB_EN
                eg = (ha.seg_sel_o === 3'b001) ? 8'h92 : 8'hFF;
`else
                eg = (ha.seg_sel_o === 3'b001) ? 8'h92 : 8'hC0;
`endif
                checks++;
                if (ha.seg_display_o !== eg) begin
                    errors++;
                    $display("FAIL lzb sel=%b: got %h want %h", ha.seg_sel_o, ha.seg_display_o, eg);
                end
            end
            checks++;
            if ({ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o} !== exp_vec(0)) begin
                errors++;
                $display("FAIL lzb_model: got %h want %h", {ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o}, exp_vec(0));
            end
            step();
        end
    endtask

    task automatic test_bcd();
        int          wraps;
        bit          seen100;
        logic [11:0] prev;
        wraps = 0; seen100 = 1'b0;
        hb.en_i = 1'b1; hb.up_dn_i = 1'b1;
        prev = hb.count_o;
        for (int c = 0; c < 1000 * 4 + 4; c++) begin
            step();
            checks++;
            if ({hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o} !== exp_vec(1)) begin
                errors++;
                $display("FAIL bcd_count c=%0d: got %h want %h", c, {hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o}, exp_vec(1));
            end
            if (prev === 12'h099 && hb.count_o !== 12'h099) begin
                seen100 = 1'b1;
                checks++;
                if ({hb.count_o, hb.wrap_o} !== {12'h100, 1'b0}) begin
                    errors++;
                    $display("FAIL bcd_099: got %h/%b want 100/0", hb.count_o, hb.wrap_o);
                end
            end
            if (hb.wrap_o === 1'b1) begin
                wraps++;
                checks++;
                if ({prev, hb.count_o} !== {12'h999, 12'h000}) begin
                    errors++;
                    $display("FAIL bcd_wrap: got %h->%h want 999->000", prev, hb.count_o);
                end
            end
            prev = hb.count_o;
        end
        checks++;
        if (wraps != 1 || !seen100) begin
            errors++;
            $display("FAIL bcd_events: got wraps=%0d seen100=%0d want 1/1", wraps, seen100);
        end
    endtask

    task automatic test_dp();
        hb.en_i = 1'b0; hb.dp_i = 3'b010;
        repeat (24) step();
        for (int c = 0; c < 24; c++) begin
            if (hb.seg_sel_o !== 3'b111) begin
                checks++;
                if (hb.seg_display_o[7] !== (hb.seg_sel_o === 3'b101)) begin
                    errors++;
                    $display("FAIL dp sel=%b: got bit7=%b want %b", hb.seg_sel_o, hb.seg_display_o[7], (hb.seg_sel_o === 3'b101));
                end
            end
            checks++;
            if ({hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o} !== exp_vec(1)) begin
                errors++;
                $display("FAIL dp_model: got %h want %h", {hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o}, exp_vec(1));
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            ha.en_i    = ($urandom_range(0, 3) != 0);
            ha.clr_i   = ($urandom_range(0, 63) == 0);
            ha.up_dn_i = ($urandom_range(0, 15) != 0) ? ha.up_dn_i : ~ha.up_dn_i;
            ha.dp_i    = 3'($urandom_range(0, 7));
            rst_a      = ($urandom_range(0, 499) == 0);
            hb.en_i    = ($urandom_range(0, 3) != 0);
            hb.clr_i   = ($urandom_range(0, 63) == 0);
            hb.up_dn_i = $urandom_range(0, 1) != 0;
            hb.dp_i    = 3'($urandom_range(0, 7));
            step();
            checks++;
            if ({ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o} !== exp_vec(0)) begin
                errors++;
                $display("FAIL rand_hex c=%0d: got %h want %h", c, {ha.count_o, ha.wrap_o, ha.seg_sel_o, ha.seg_display_o}, exp_vec(0));
            end
            checks++;
            if ({hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o} !== exp_vec(1)) begin
                errors++;
                $display("FAIL rand_bcd c=%0d: got %h want %h", c, {hb.count_o, hb.wrap_o, hb.seg_sel_o, hb.seg_display_o}, exp_vec(1));
            end
        end
        rst_a = 1'b0; ha.clr_i = 1'b0; hb.clr_i = 1'b0;
    endtask

    initial begin
        ha.en_i = 1'b0; ha.clr_i = 1'b0; ha.up_dn_i = 1'b1; ha.dp_i = 3'b000;
        hb.en_i = 1'b0; hb.clr_i = 1'b0; hb.up_dn_i = 1'b1; hb.dp_i = 3'b000;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_t[i] = 0; m_lat[i] = 0;
            m_wrap[i] = 1'b0; m_latdp[i] = 3'b000;
        end
        test_reset();
        test_idle_scan();
        test_count_up_wrap();
        test_count_down();
        test_clear();
        test_rst_mid_drive();
        test_lzb();
        test_bcd();
        test_dp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/svn_seg_mux_cntr.md
Name: svn_seg_mux_cntr

Overview:
Parametrised multi-digit 7-segment counter/display driver for board bring-up. It holds an N-digit hex or BCD up/down counter advanced by a programmable prescaler. The digits are time-multiplexed onto a shared segment bus with per-digit select lines and an anti-ghosting blank interval. It sits directly at the board display pins and can be driven by a board-check top or a status source.

Parameters:
NUM_DIGITS, 3, digits on display, 1..8; digit 0 is least significant and maps to seg_sel_o[0].
COUNT_DIV, 125000000, clk cycles per count tick (1 Hz at 125 MHz), >=1.
SCAN_DIV, 125000, clk cycles per digit slot, > BLANK_CYC.
BLANK_CYC, 64, cycles per slot with all selects inactive, >=1.
BCD_MODE, 1'b0, 1 = each digit counts 0..9; 0 = each digit counts 0..F.
LED_POLARITY, 1'b0, segment active level (0 = active-low).
SEL_POLARITY, 1'b1, digit-select active level.

Ports:
clk_i  in  1  single clock.
rst_i  in  1  reset, synchronous, active-high.
en_i  in  1  count enable; low freezes the count prescaler and the count.
clr_i  in  1  synchronous clear of count and count prescaler.
up_dn_i  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
dp_i  in  NUM_DIGITS  decimal-point request per digit.
count_o  out  4*NUM_DIGITS  current count, digit k at [4k+3:4k].
wrap_o  out  1  one-cycle pulse on full-range wrap.
seg_display_o  out  8  segments; bit0=a .. bit6=g, bit7=dp.
seg_sel_o  out  NUM_DIGITS  digit selects.

Behaviour:
- Reset (rst_i=1 at a clk edge):
  - count_o=0, wrap_o=0, both prescalers=0, scan index=0, FSM=BLANK.
  - seg_sel_o = all inactive.
  - seg_display_o = off (8'hFF if LED_POLARITY=0, else 8'h00).
- Count prescaler:
  - Advances only while en_i=1.
  - Terminal count at COUNT_DIV-1 wraps to 0 and produces a tick.
  - COUNT_DIV=1 gives a tick on every enabled cycle.
- Counter: updates on the clk edge of a tick cycle.
  - Up: digit0+1; a digit at max (9 or F) goes to 0 and carries to the next digit.
  - Down: digit0-1; a digit at 0 goes to max and borrows from the next digit.
  - Full wrap: up from all-max to all-0, or down from all-0 to all-max. wrap_o=1 on the same edge count_o changes, for one cycle only.
- clr_i priority over tick: count_o=0, prescaler=0, wrap_o=0; no wrap pulse.
- en_i=0 with clr_i=1 still clears.
- Scan FSM, free-running and independent of en_i:
  - BLANK: lasts BLANK_CYC cycles; selects all inactive, segments off.
  - BLANK -> DRIVE.
  - DRIVE: lasts SCAN_DIV-BLANK_CYC cycles; seg_sel_o has only bit[idx] active.
  - DRIVE -> BLANK; idx = (idx==NUM_DIGITS-1) ? 0 : idx+1.
- Segment pattern:
  - Registered on entry to DRIVE from count_o digit idx and dp_i[idx]; held for the whole slot. Count changes mid-slot appear at the next visit to that digit.
  - Hex patterns (active-high, bit7=0): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - bit7 = dp_i[idx].
  - Output = LED_POLARITY ? pattern : ~pattern.
- All outputs are registered; no combinational path from inputs to outputs.
- NUM_DIGITS=1: idx stays 0; the BLANK/DRIVE alternation is kept.

Optional Feature:
- Macro SVN_SEG_LZB_EN (leading-zero blanking).
- Defined: during DRIVE, a digit is blanked (segments off, select still active) when its value is 0, it is not digit 0, and all higher digits are 0. dp_i still drives bit7 on a blanked digit.
- Undefined: every digit shows its pattern, including leading zeros.

Test Plan:
Unless stated, NUM_DIGITS=3, COUNT_DIV=4, SCAN_DIV=8, BLANK_CYC=2, BCD_MODE=0, LED_POLARITY=0, SEL_POLARITY=1.
- Reset then idle 24 cycles with en_i=0 -> count_o=12'h000; slot pattern is 2 cycles sel=000 then 6 cycles sel=001 with seg=~3F=C0, then sel=010, then 100, then repeating.
- en_i=1, up_dn_i=1 -> count_o increments every 4 cycles; after 4096 ticks it goes FFF->000 with wrap_o high exactly 1 cycle on that edge.
- BCD_MODE=1, count at 099, one tick -> count_o=12'h100, no wrap_o; at 999 with one tick -> 000 and wrap_o=1.
- up_dn_i=0 from 000 -> FFF with wrap_o=1; next tick -> FFE.
- clr_i=1 on the tick cycle at count 0FF -> count_o=000, no wrap_o; prescaler restarts so the next increment is 4 cycles later. rst_i asserted mid-DRIVE -> next cycle sel=000, seg=FF.
- dp_i=3'b010 with LED_POLARITY=1 -> digit-1 slot shows bit7=1, others bit7=0. With SVN_SEG_LZB_EN and count 005 -> digits 2 and 1 are off, digit 0 shows 6D.
